// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, constants and helpers for the SIPO frame receiver
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DATA_WIDTH_DEF = 8;

  // Counter width able to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - right-shifting serial-in/parallel-out register, serial_in enters the MSB
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  shift_enable,
  output logic [DATA_WIDTH-1:0] parallel_out
);

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_d;

  // Shift one bit in from the top when enabled, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (shift_enable) begin
      sr_d = {serial_in, sr_q[DATA_WIDTH-1:1]};
    end
  end

  // Register the shift stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign parallel_out = sr_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - frame sequencer: bit/byte counting, byte holding register, handshake and status flags
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int FRAME_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  serial_in,
  input  logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic                  byte_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int BIT_W  = cnt_width(DATA_WIDTH);
  localparam int BYTE_W = cnt_width(FRAME_BYTES + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BYTE_W-1:0] FRAME_LAST = BYTE_W'(FRAME_BYTES);

  state_e                state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]     byte_cnt_inc;
  logic [DATA_WIDTH-1:0] byte_data_q, byte_data_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_error_q, frame_error_d;

  logic                  shift_enable;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] new_byte;
  logic                  unused_sr_lsb;

  sipo_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shift_reg (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .parallel_out (sr)
  );

  // The completing byte is taken from the shifter's next value so it lands in
  // the holding register on the same edge as the last bit.
  assign new_byte      = {serial_in, sr[DATA_WIDTH-1:1]};
  assign unused_sr_lsb = sr[0];
  assign byte_cnt_inc  = byte_cnt_q + 1'b1;

  // Next-state, counter, holding-register and flag logic; frame_start has priority over bits.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = byte_valid_q;
    overrun_d     = overrun_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    shift_enable  = 1'b0;

    // Downstream acceptance frees the holding register; a completion below may refill it.
    if (byte_valid_q && byte_ready) begin
      byte_valid_d = 1'b0;
    end

    if (frame_start) begin
      if ((state_q == SHIFT) && ((bit_cnt_q != '0) || (byte_cnt_q != '0))) begin
        frame_error_d = 1'b1;
      end
      state_d    = SHIFT;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      overrun_d  = 1'b0;
    end else if ((state_q == SHIFT) && bit_valid) begin
      shift_enable = 1'b1;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d  = '0;
        byte_cnt_d = byte_cnt_inc;
        if (!byte_valid_q || byte_ready) begin
          byte_data_d  = new_byte;
          byte_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (byte_cnt_inc == FRAME_LAST) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // State, counters, holding register and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign busy        = (state_q == SHIFT);
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - self-checking bench for sipo_frame_ctrl with vector table, directed corners and random traffic
module tb_sipo_frame_ctrl;

  localparam int FB = 4;

  logic       clk = 1'b0;
  logic       reset, frame_start, bit_valid, serial_in, byte_ready;
  logic [7:0] byte_data;
  logic       byte_valid, busy, frame_done, overrun, frame_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(
    .DATA_WIDTH  (8),
    .FRAME_BYTES (FB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .serial_in   (serial_in),
    .byte_ready  (byte_ready),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  // Reference model: bits collected arithmetically, bytes counted per frame.
  bit         m_busy, m_valid, m_done, m_ovr, m_err;
  int         m_nbits, m_nbytes, m_acc;
  logic [7:0] m_data;

  function automatic void model_step(input bit rst, input bit fs, input bit bv,
                                     input bit si, input bit br);
    if (rst) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_ovr = 0; m_err = 0;
      m_nbits = 0; m_nbytes = 0; m_acc = 0; m_data = 8'h00;
      return;
    end
    m_done = 0;
    m_err  = 0;
    if (m_valid && br) m_valid = 0;
    if (fs) begin
      if (m_busy && (m_nbits != 0 || m_nbytes != 0)) m_err = 1;
      m_busy = 1; m_nbits = 0; m_acc = 0; m_nbytes = 0; m_ovr = 0;
    end else if (m_busy && bv) begin
      m_acc = m_acc + (int'(si) << m_nbits);
      m_nbits = m_nbits + 1;
      if (m_nbits == 8) begin
        if (!m_valid) begin
          m_data  = m_acc[7:0];
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
        m_nbits  = 0;
        m_acc    = 0;
        m_nbytes = m_nbytes + 1;
        if (m_nbytes == FB) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit fs, input bit bv, input bit si, input bit br);
    reset       = rst;
    frame_start = fs;
    bit_valid   = bv;
    serial_in   = si;
    byte_ready  = br;
    model_step(rst, fs, bv, si, br);
    @(posedge clk);
    #1;
    chk("model", {byte_data, byte_valid, busy, frame_done, overrun, frame_error},
        {m_data, m_valid, m_busy, m_done, m_ovr, m_err});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit br, input bit br_last);
    for (int i = 0; i < 8; i++) begin
      if (gaps && (i % 3 == 1)) step(0, 0, 0, 0, br);
      step(0, 0, 1, b[i], (i == 7) ? br_last : br);
    end
  endtask

  typedef struct {
    bit         fs, bv, si, br;
    bit         ev;
    logic [7:0] ed;
    bit         eb, edone, eerr;
  } vec_t;

  vec_t       vt[12];
  logic [7:0] frame_bytes[4];

  initial begin
    // Basic byte 0xA5, LSB first: 1,0,1,0,0,1,0,1
    vt[0]  = '{1, 0, 0, 1, 0, 8'h00, 1, 0, 0};
    vt[1]  = '{0, 1, 1, 1, 0, 8'h00, 1, 0, 0};
    vt[2]  = '{0, 1, 0, 1, 0, 8'h00, 1, 0, 0};
    vt[3]  = '{0, 1, 1, 1, 0, 8'h00, 1, 0, 0};
    vt[4]  = '{0, 1, 0, 1, 0, 8'h00, 1, 0, 0};
    vt[5]  = '{0, 1, 0, 1, 0, 8'h00, 1, 0, 0};
    vt[6]  = '{0, 1, 1, 1, 0, 8'h00, 1, 0, 0};
    vt[7]  = '{0, 1, 0, 1, 0, 8'h00, 1, 0, 0};
    vt[8]  = '{0, 1, 1, 1, 1, 8'hA5, 1, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 1, 8'hA5, 1, 0, 0};
    vt[10] = '{0, 0, 0, 1, 0, 8'hA5, 1, 0, 0};
    vt[11] = '{1, 0, 0, 0, 0, 8'hA5, 1, 0, 1};
    frame_bytes[0] = 8'h01;
    frame_bytes[1] = 8'h80;
    frame_bytes[2] = 8'hFF;
    frame_bytes[3] = 8'h3C;

    // Reset state, and bit_valid ignored while idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    chk("rst_outputs", {byte_data, byte_valid, busy, frame_done, overrun, frame_error}, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    chk("idle_bits_valid", byte_valid, 0);
    chk("idle_bits_busy", busy, 0);

    // Vector table: single byte, handshake, restart after a completed byte
    for (int i = 0; i < 12; i++) begin
      step(0, vt[i].fs, vt[i].bv, vt[i].si, vt[i].br);
      chk($sformatf("vec%0d_valid", i), byte_valid, vt[i].ev);
      chk($sformatf("vec%0d_data", i), byte_data, vt[i].ed);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].eb);
      chk($sformatf("vec%0d_done", i), frame_done, vt[i].edone);
      chk($sformatf("vec%0d_err", i), frame_error, vt[i].eerr);
    end

    // Full frame with gaps
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      send_byte(frame_bytes[k], 1, 1, 1);
      chk($sformatf("frame_b%0d_data", k), byte_data, frame_bytes[k]);
      chk($sformatf("frame_b%0d_valid", k), byte_valid, 1);
      chk($sformatf("frame_b%0d_done", k), frame_done, (k == 3));
    end
    step(0, 0, 0, 0, 1);
    chk("frame_end_busy", busy, 0);
    chk("frame_end_done", frame_done, 0);
    send_byte(8'h77, 0, 1, 1);
    chk("post_frame_valid", byte_valid, 0);
    chk("post_frame_data", byte_data, 8'h3C);

    // Overrun and same-cycle refill
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    send_byte(8'h11, 0, 0, 0);
    chk("ovr_first_data", byte_data, 8'h11);
    send_byte(8'h22, 0, 0, 0);
    chk("ovr_hold_data", byte_data, 8'h11);
    chk("ovr_flag", overrun, 1);
    send_byte(8'h33, 0, 0, 1);
    chk("ovr_refill_data", byte_data, 8'h33);
    chk("ovr_refill_valid", byte_valid, 1);
    chk("ovr_sticky", overrun, 1);
    send_byte(8'h44, 0, 0, 0);
    chk("ovr_drop_done", frame_done, 1);
    chk("ovr_drop_data", byte_data, 8'h33);
    chk("ovr_drop_busy", busy, 0);
    step(0, 1, 0, 0, 0);
    chk("ovr_cleared", overrun, 0);
    chk("ovr_restart_err", frame_error, 0);

    // Abort after 5 bits, then a clean byte; abort coinciding with a completing bit
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    chk("abort_err", frame_error, 1);
    chk("abort_valid", byte_valid, 0);
    step(0, 0, 0, 0, 1);
    chk("abort_err_pulse", frame_error, 0);
    send_byte(8'h5A, 0, 1, 1);
    chk("abort_next_data", byte_data, 8'h5A);
    chk("abort_next_valid", byte_valid, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    chk("abort_last_err", frame_error, 1);
    chk("abort_last_valid", byte_valid, 0);
    chk("abort_last_data", byte_data, 8'h5A);

    // Reset mid-byte and mid-frame
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_mid_byte", {byte_data, byte_valid, busy, frame_done, overrun, frame_error}, 0);
    step(0, 1, 0, 0, 0);
    send_byte(8'h12, 0, 0, 0);
    send_byte(8'h34, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_mid_frame", {byte_data, byte_valid, busy, frame_done, overrun, frame_error}, 0);
    step(0, 1, 0, 0, 0);
    send_byte(8'hC3, 0, 1, 1);
    chk("rst_new_data", byte_data, 8'hC3);
    chk("rst_new_valid", byte_valid, 1);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit rst_r, fs_r;
      rst_r = ($urandom % 600) == 0;
      fs_r  = m_busy ? (($urandom % 200) == 0) : (($urandom % 8) == 0);
      step(rst_r, fs_r, ($urandom % 10) < 6, $urandom % 2, $urandom % 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
